// File: rtl/ransac_fixed_pkg.sv
// ransac_fixed: shared Q24.24 fixed-point types for the RANSAC datapath.
//
// Contents:
//   fixed_t       48-bit signed Q24.24 value
//   product_t     96-bit signed full product of two fixed_t
//   fma_sum_t     74-bit signed rescaled-product plus addend
//   fma_opcode_t  sign selection for R = +/-A*B +/- C
//   fma_neg_t     decoded {neg_a, neg_c} flags
//   one()         fixed-point 1.0
//   fma_decode()  opcode to negate flags
package ransac_fixed;

  localparam int unsigned DATA_W      = 48;
  localparam int unsigned FRAC_W      = 24;
  localparam int unsigned fma_latency = 3;

  typedef logic signed [DATA_W-1:0]            fixed_t;
  typedef logic signed [2*DATA_W-1:0]          product_t;
  // Rescaled product needs 2*DATA_W-FRAC_W bits; one more for the sign of
  // the shifted range and one more for the carry of the add.
  typedef logic signed [2*DATA_W-FRAC_W+1:0]   fma_sum_t;

  typedef enum logic [1:0] {
    FMA_POS_A_POS_C = 2'b00,
    FMA_POS_A_NEG_C = 2'b01,
    FMA_NEG_A_POS_C = 2'b10,
    FMA_NEG_A_NEG_C = 2'b11
  } fma_opcode_t;

  typedef struct packed {
    logic neg_a;
    logic neg_c;
  } fma_neg_t;

  function automatic int unsigned value_bits();
    return DATA_W;
  endfunction

  function automatic int unsigned fraction_bits();
    return FRAC_W;
  endfunction

  function automatic fixed_t one();
    fixed_t v;
    v         = '0;
    v[FRAC_W] = 1'b1;
    return v;
  endfunction

  function automatic fma_neg_t fma_decode(fma_opcode_t op);
    fma_neg_t f;
    f.neg_a = (op == FMA_NEG_A_POS_C) || (op == FMA_NEG_A_NEG_C);
    f.neg_c = (op == FMA_POS_A_NEG_C) || (op == FMA_NEG_A_NEG_C);
    return f;
  endfunction

endpackage

// File: rtl/ransac_fixed_reduce.sv
// ransac_fixed_reduce: combinational narrowing of an fma_sum_t to fixed_t.
//
// Build option: RANSAC_FMA_SATURATE_EN
//   defined   -> clamp to the fixed_t range, sat_o flags a clamp
//   undefined -> two's-complement wrap (low DATA_W bits), sat_o = 0
//
// Ports:
//   sum_i  in  fma_sum_t  full-precision sum
//   r_o    out fixed_t    reduced result
//   sat_o  out 1          result was clamped
module ransac_fixed_reduce
  import ransac_fixed::*;
(
  input  fma_sum_t sum_i,
  output fixed_t   r_o,
  output logic     sat_o
);

  localparam int SUM_W = $bits(fma_sum_t);

`ifdef RANSAC_FMA_SATURATE_EN
  logic in_range;

  always_comb begin
    // In range exactly when every bit from the fixed_t sign bit upward
    // is a copy of the sum's sign.
    in_range = (&sum_i[SUM_W-1:DATA_W-1]) | ~(|sum_i[SUM_W-1:DATA_W-1]);
    r_o      = sum_i[DATA_W-1:0];
    sat_o    = 1'b0;
    if (!in_range) begin
      sat_o = 1'b1;
      r_o   = sum_i[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^sum_i[SUM_W-1:DATA_W];
  assign r_o       = sum_i[DATA_W-1:0];
  assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/ransac_fma_unit.sv
// ransac_fma_unit: pipelined fixed-point fused multiply-add, R = +/-A*B +/- C.
//
// Build option: RANSAC_FMA_SATURATE_EN (saturate instead of wrap; see
// ransac_fixed_reduce). Latency is the same in both builds.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              request handshake
//   in_opcode                      fma_opcode_t sign selection
//   in_a, in_b, in_c               Q24.24 operands
//   in_tag [TAG_WIDTH]             opaque tag, returned with the result
//   out_valid/out_ready            result handshake
//   out_r                          Q24.24 result
//   out_tag                        tag of the producing request
//   out_sat                        result was clamped (saturating build)
//
// Three data stages (S1 operands, S2 product, S3 sum) feed an output
// register, so an accept at edge N presents its result after edge N+3.
// All stages advance together; a held output stalls the whole pipe.
module ransac_fma_unit
  import ransac_fixed::*;
#(
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  fma_opcode_t          in_opcode,
  input  fixed_t               in_a,
  input  fixed_t               in_b,
  input  fixed_t               in_c,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output fixed_t               out_r,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_sat
);

  logic adv;
  fma_neg_t neg_in;

  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic out_valid_q, out_valid_d;

  fixed_t               a_p0_q, a_p0_d, b_p0_q, b_p0_d, c_p0_q, c_p0_d;
  logic                 neg_a_p0_q, neg_a_p0_d, neg_c_p0_q, neg_c_p0_d;
  logic [TAG_WIDTH-1:0] tag_p0_q, tag_p0_d;

  product_t             prod_p1_q, prod_p1_d;
  fixed_t               c_p1_q, c_p1_d;
  logic                 neg_c_p1_q, neg_c_p1_d;
  logic [TAG_WIDTH-1:0] tag_p1_q, tag_p1_d;

  fma_sum_t             sum_p2_q, sum_p2_d;
  logic [TAG_WIDTH-1:0] tag_p2_q, tag_p2_d;

  fixed_t               out_r_q, out_r_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic                 out_sat_q, out_sat_d;

  product_t mul;
  fma_sum_t q_scaled, c_ext;
  fixed_t   red_r;
  logic     red_sat;

  // Deliberately combinational from out_ready so a draining output can
  // accept a new request on the same edge.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign neg_in   = fma_decode(in_opcode);

  always_comb begin
    vld_p0_d    = vld_p0_q;
    vld_p1_d    = vld_p1_q;
    vld_p2_d    = vld_p2_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      vld_p0_d    = in_valid;
      vld_p1_d    = vld_p0_q;
      vld_p2_d    = vld_p1_q;
      out_valid_d = vld_p2_q;
    end
  end

  always_comb begin
    mul      = product_t'(a_p0_q) * product_t'(b_p0_q);
    // Arithmetic shift floors toward -inf; the truncating cast is exact
    // because |P| <= 2^94 leaves at most 72 significant bits.
    q_scaled = fma_sum_t'(prod_p1_q >>> FRAC_W);
    c_ext    = fma_sum_t'(c_p1_q);

    a_p0_d     = a_p0_q;
    b_p0_d     = b_p0_q;
    c_p0_d     = c_p0_q;
    neg_a_p0_d = neg_a_p0_q;
    neg_c_p0_d = neg_c_p0_q;
    tag_p0_d   = tag_p0_q;
    prod_p1_d  = prod_p1_q;
    c_p1_d     = c_p1_q;
    neg_c_p1_d = neg_c_p1_q;
    tag_p1_d   = tag_p1_q;
    sum_p2_d   = sum_p2_q;
    tag_p2_d   = tag_p2_q;
    out_r_d    = out_r_q;
    out_tag_d  = out_tag_q;
    out_sat_d  = out_sat_q;

    if (adv) begin
      // S1: operands and decoded negate flags
      a_p0_d     = in_a;
      b_p0_d     = in_b;
      c_p0_d     = in_c;
      neg_a_p0_d = neg_in.neg_a;
      neg_c_p0_d = neg_in.neg_c;
      tag_p0_d   = in_tag;
      // S2: full-width signed product, negated for -A
      prod_p1_d  = neg_a_p0_q ? -mul : mul;
      c_p1_d     = c_p0_q;
      neg_c_p1_d = neg_c_p0_q;
      tag_p1_d   = tag_p0_q;
      // S3: rescale and add/subtract C
      sum_p2_d   = neg_c_p1_q ? (q_scaled - c_ext) : (q_scaled + c_ext);
      tag_p2_d   = tag_p1_q;
      // Output: narrowed to fixed_t
      out_r_d    = red_r;
      out_tag_d  = tag_p2_q;
      out_sat_d  = red_sat;
    end
  end

  ransac_fixed_reduce u_reduce (
    .sum_i (sum_p2_q),
    .r_o   (red_r),
    .sat_o (red_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
      out_sat_q   <= out_sat_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p0_q     <= a_p0_d;
    b_p0_q     <= b_p0_d;
    c_p0_q     <= c_p0_d;
    neg_a_p0_q <= neg_a_p0_d;
    neg_c_p0_q <= neg_c_p0_d;
    tag_p0_q   <= tag_p0_d;
    prod_p1_q  <= prod_p1_d;
    c_p1_q     <= c_p1_d;
    neg_c_p1_q <= neg_c_p1_d;
    tag_p1_q   <= tag_p1_d;
    sum_p2_q   <= sum_p2_d;
    tag_p2_q   <= tag_p2_d;
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_ransac_fma_unit.sv
// Testbench for ransac_fma_unit: directed vectors, an arithmetic reference
// model with an in-order expectation queue, and literal expectations.
module tb_ransac_fma_unit;
  import ransac_fixed::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fma_opcode_t in_opcode;
  logic [47:0] in_a, in_b, in_c;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_r;
  logic [7:0]  out_tag;
  logic        out_sat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stl    = 0;

  ransac_fma_unit #(.TAG_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: exact wide arithmetic, floor division by 2^24, then the
  // build's overflow rule. Returns {sat, r}.
  function automatic logic [48:0] model_fma(fma_opcode_t op, logic signed [47:0] a,
                                            logic signed [47:0] b, logic signed [47:0] c);
    logic signed [127:0] wa, wb, wc, p, s;
    logic [47:0] r;
    logic sat;
    wa = a; wb = b; wc = c;
    p = wa * wb;
    if (op == FMA_NEG_A_POS_C || op == FMA_NEG_A_NEG_C) p = -p;
    p = p >>> 24;
    if (op == FMA_POS_A_NEG_C || op == FMA_NEG_A_NEG_C) s = p - wc;
    else s = p + wc;
    r   = 48'(s);
    sat = 1'b0;
`ifdef RANSAC_FMA_SATURATE_EN
    if (s > 128'sh7FFF_FFFF_FFFF) begin
      r = 48'h7FFF_FFFF_FFFF; sat = 1'b1;
    end else if (s < -128'sh8000_0000_0000) begin
      r = 48'h8000_0000_0000; sat = 1'b1;
    end
`endif
    return {sat, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [47:0] r;
    logic        sat;
    logic [7:0]  tag;
    int          acc;
    int          stl;
    bit          seen;
  } exp_t;
  exp_t mq[$];
  logic [7:0] hs_tags[$];
  int         hs_cyc[$];

  // Compare process: in-order results, values and latency (3 edges plus
  // any stall edges while the request was in flight).
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (out_valid) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual_tag=%0h required=no_result", out_tag);
        end else begin
          chk("mon_r", 64'(out_r), 64'(mq[0].r));
          chk("mon_tag", 64'(out_tag), 64'(mq[0].tag));
          chk("mon_sat", 64'(out_sat), 64'(mq[0].sat));
          if (!mq[0].seen) begin
            chk("mon_latency", 64'(cyc), 64'(mq[0].acc + 3 + (stl - mq[0].stl)));
            mq[0].seen = 1'b1;
          end
          if (out_ready) begin
            hs_tags.push_back(out_tag);
            hs_cyc.push_back(cyc);
            void'(mq.pop_front());
          end
        end
      end
      if (!in_ready) stl++;
      if (in_valid && in_ready) begin
        logic [48:0] m;
        exp_t e;
        m = model_fma(in_opcode, in_a, in_b, in_c);
        e.r = m[47:0]; e.sat = m[48]; e.tag = in_tag;
        e.acc = cyc + 1; e.stl = stl; e.seen = 1'b0;
        mq.push_back(e);
      end
    end
  end

  typedef struct {
    fma_opcode_t op;
    logic [47:0] a, b, c, er;
    logic        es;
  } vec_t;
  vec_t vecs[5];

  task automatic run1(input int i, input logic [7:0] tag);
    int acc;
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = vecs[i].op;
    in_a = vecs[i].a; in_b = vecs[i].b; in_c = vecs[i].c; in_tag = tag;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && cyc < acc + 10) @(negedge clk);
    chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d_latency", i), 64'(cyc - acc), 64'd3);
    chk($sformatf("v%0d_r", i), 64'(out_r), 64'(vecs[i].er));
    chk($sformatf("v%0d_tag", i), 64'(out_tag), 64'(tag));
    chk($sformatf("v%0d_sat", i), 64'(out_sat), 64'(vecs[i].es));
  endtask

  initial begin
    logic [47:0] held_r;
    logic [7:0]  held_tag;
    bit acc_ok, saw_valid;
    int t, k;

    vecs[0] = '{FMA_POS_A_POS_C, 48'h1800000, 48'h2000000, 48'h400000, 48'h3400000, 1'b0};
    vecs[1] = '{FMA_NEG_A_NEG_C, 48'h1800000, 48'h2000000, 48'h400000, 48'hFFFF_FCC0_0000, 1'b0};
    vecs[2] = '{FMA_POS_A_NEG_C, 48'h1800000, 48'h2000000, 48'h400000, 48'h2C00000, 1'b0};
    vecs[3] = '{FMA_POS_A_POS_C, 48'h1, 48'hFFFF_FF80_0000, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0};
`ifdef RANSAC_FMA_SATURATE_EN
    vecs[4] = '{FMA_POS_A_POS_C, 48'h4000_0000_0000, 48'h4000000, 48'h0, 48'h7FFF_FFFF_FFFF, 1'b1};
`else
    vecs[4] = '{FMA_POS_A_POS_C, 48'h4000_0000_0000, 48'h4000000, 48'h0, 48'h0, 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; in_opcode = FMA_POS_A_POS_C;
    in_a = '0; in_b = '0; in_c = '0; in_tag = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Model pinned to hand-computed values.
    for (int i = 0; i < 5; i++)
      chk($sformatf("pin_model_%0d", i),
          64'(model_fma(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c)),
          64'({vecs[i].es, vecs[i].er}));

    for (int i = 0; i < 5; i++) run1(i, 8'h40 + 8'(i));

    // Back-to-back stream at full rate.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_opcode = vecs[i].op;
      in_a = vecs[i].a; in_b = vecs[i].b; in_c = vecs[i].c; in_tag = 8'h20 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Back-pressure: six requests against a stalled consumer.
    hs_tags.delete(); hs_cyc.delete();
    out_ready = 1'b0; t = 0; k = 0;
    held_r = '0; held_tag = '0;
    while (hs_tags.size() < 6 && k < 60) begin
      if (t < 6) begin
        in_valid = 1'b1; in_opcode = FMA_POS_A_POS_C;
        in_a = 48'(t + 1) << 24; in_b = one(); in_c = 48'(t); in_tag = 8'(t);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc_ok = in_valid && in_ready;
      if (k == 6) begin
        held_r = out_r; held_tag = out_tag;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head_tag", 64'(out_tag), 64'd0);
        chk("bp_head_r", 64'(out_r), 64'h1000000);
        chk("bp_accepted", 64'(t), 64'd4);
      end
      if (k > 6 && k < 10) begin
        chk("bp_hold_r", 64'(out_r), 64'(held_r));
        chk("bp_hold_tag", 64'(out_tag), 64'(held_tag));
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      if (acc_ok) t++;
      k++;
      if (k == 10) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(hs_tags.size()), 64'd6);
    for (int i = 0; i < hs_tags.size(); i++) begin
      chk($sformatf("bp_order_%0d", i), 64'(hs_tags[i]), 64'(i));
      if (i > 0) chk($sformatf("bp_rate_%0d", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
    end

    // Reset with one result held at the output and three behind it.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_opcode = FMA_POS_A_POS_C;
      in_a = one(); in_b = one(); in_c = '0; in_tag = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_out_r", 64'(out_r), 64'd0);
    chk("mid_out_tag", 64'(out_tag), 64'd0);
    chk("mid_out_sat", 64'(out_sat), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("mid_no_stale", 64'(saw_valid), 64'd0);
    chk("end_queue_empty", 64'(mq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
